adder_result_disp: RTL and testbench
====================================

ADDER_RESULT_DISP -- requirements
Module: adder_result_disp

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each display digit stays lit (minimum 2).
REQ-002 The block SHALL have parameter DB_CNT, default 1000000, giving the consecutive stable cycles needed to accept a key change (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Si, input, 4 bits: sum bits from the 4-bit adder stage.
REQ-006 The block SHALL have port Co, input, 1 bit: carry-out from the adder stage.
REQ-007 The block SHALL have port key_n, input, 1 bit: raw active-low capture pushbutton, asynchronous to clk.
REQ-008 The block SHALL have port live, input, 1 bit: 1 = the result register tracks the inputs every cycle; 0 = it loads only on a key press.
REQ-009 The block SHALL have port result, output, 5 bits: registered {Co,Si}, value 0..31.
REQ-010 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a key-press capture.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low segments, with seg[0]=a through seg[6]=g.
REQ-012 The block SHALL have port an, output, 2 bits: active-low digit enables, with an[0]=units and an[1]=tens.

Function
REQ-013 key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debouncer SHALL hold a stable state (reset 1) and a counter, handled as follows:
- synced value equals stable state -> counter cleared.
- synced value differs -> counter increments.
- counter reaches DB_CNT-1 -> stable state takes the synced value and the counter clears.
REQ-015 A capture pulse SHALL be generated for exactly one cycle when the stable state goes 1->0; release (0->1) SHALL generate nothing.
REQ-016 A held key SHALL generate only one capture; any glitch shorter than DB_CNT cycles SHALL generate none.
REQ-017 On a capture pulse, result SHALL load {Co,Si} and valid SHALL be 1, both on the same clock edge.
REQ-018 When live=1, result SHALL load {Co,Si} every cycle.
REQ-019 A capture occurring while live=1 SHALL still pulse valid.
REQ-020 When live=0 and there is no capture, result SHALL hold its value.
REQ-021 tens SHALL be derived combinationally from result: 3 if result>=30, else 2 if >=20, else 1 if >=10, else 0.
REQ-022 units SHALL equal result-10*tens, a 4-bit value 0..9.
REQ-023 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count the digit select sel SHALL toggle (reset sel=0).
REQ-024 seg and an SHALL be registered, one cycle after sel or result changes, with this decode:
- sel=0 -> an=2'b10, seg=code(units).
- sel=1 with tens!=0 -> an=2'b01, seg=code(tens).
- sel=1 with tens=0 -> an=2'b11 and seg=7'h7F (leading-zero blanking).
REQ-025 Segment codes (seg[6:0]) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-026 Because units is always 0..9, no other codes SHALL be reachable.
REQ-027 An input change simultaneous with a capture SHALL load the value present at that clock edge.

Reset
REQ-028 While rst_n=0, the outputs SHALL immediately be result=0, valid=0, seg=7'h7F and an=2'b11, independent of clk.
REQ-029 While rst_n=0, internally the synchronizer and stable state SHALL be 1, the debounce and scan counters 0, and sel=0.
REQ-030 On the first clock edge after reset releases, the block SHALL show units "0": an=2'b10, seg=7'h40.
REQ-031 Reset asserted mid-press SHALL discard the debounce progress.
REQ-032 After a reset, a key still held low SHALL be accepted as a new press only after DB_CNT stable-low cycles.

Verification (SCAN_DIV=4, DB_CNT=8)
REQ-033 Reset: assert rst_n=0 mid-cycle -> result=0, valid=0, seg=7F, an=11 immediately; after release -> an=10, seg=40.
REQ-034 Capture: live=0, Si=F, Co=1, key_n low for 30 cycles -> exactly one valid pulse and result=31; display alternates an=10/seg=79 and an=01/seg=30 every 4 cycles.
REQ-035 Bounce: key_n toggling every 3 cycles for 40 cycles, then held high -> no valid pulse and result unchanged.
REQ-036 Live mode: live=1, {Co,Si} goes 5->9 -> result follows one edge later and valid stays 0; with tens=0, the tens slot shows an=11, seg=7F.
REQ-037 Boundary value: capture {Co,Si}=10 -> tens slot seg=79, units slot seg=40.
REQ-038 Capture {Co,Si}=9 -> tens slot blanked, units slot seg=10.
REQ-039 Reset mid-press: hold key_n low for 5 cycles, pulse rst_n, keep key_n low -> valid fires exactly once, 8+ cycles after reset release (plus the synchronizer delay).

Source files
------------

// File: rtl/adder_result_disp.sv
// Captures the 5-bit adder result on a debounced key press (or continuously in live mode)
// and shows it in decimal on a two-digit multiplexed active-low 7-segment display.
module adder_result_disp #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DB_CNT   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Si,
  input  logic       Co,
  input  logic       key_n,
  input  logic       live,
  output logic [4:0] result,
  output logic       valid,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned DB_W   = (DB_CNT > 2) ? $clog2(DB_CNT) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              sync1;
  logic              sync2;
  logic              stable;
  logic [DB_W-1:0]   db_cnt;
  logic              capture_c;
  logic [SCAN_W-1:0] scan_cnt;
  logic              sel;
  logic [1:0]        tens_c;
  logic [3:0]        units_c;
  logic [6:0]        seg_next;
  logic [1:0]        an_next;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous pushbutton
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Press is accepted on the edge where a low level has persisted long enough
  assign capture_c = (sync2 != stable) && (db_cnt == DB_LAST) && !sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= capture_c;
      if (capture_c || live) begin
        result <= {Co, Si};
      end
    end
  end

  // Digit scan: each digit stays lit for SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sel      <= ~sel;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Binary to two decimal digits; result never exceeds 31
  always_comb begin
    tens_c  = 2'd0;
    units_c = 4'(result);
    if (result >= 5'd30) begin
      tens_c  = 2'd3;
      units_c = 4'(result - 5'd30);
    end else if (result >= 5'd20) begin
      tens_c  = 2'd2;
      units_c = 4'(result - 5'd20);
    end else if (result >= 5'd10) begin
      tens_c  = 2'd1;
      units_c = 4'(result - 5'd10);
    end
  end

  // Tens digit is blanked when it would be a leading zero
  always_comb begin
    an_next  = 2'b11;
    seg_next = 7'h7F;
    if (!sel) begin
      an_next  = 2'b10;
      seg_next = seg_code(units_c);
    end else if (tens_c != 2'd0) begin
      an_next  = 2'b01;
      seg_next = seg_code({2'b00, tens_c});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      an  <= 2'b11;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_adder_result_disp.sv
// Bench for adder_result_disp: directed scenarios plus randomized key/adder traffic,
// every cycle compared against a behavioural model of capture and decimal display.
module tb_adder_result_disp;

  localparam int SCAN = 4;
  localparam int DB   = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] si;
  logic       co;
  logic       key_n;
  logic       live;
  logic [4:0] result;
  logic       valid;
  logic [6:0] seg;
  logic [1:0] an;

  adder_result_disp #(.SCAN_DIV(SCAN), .DB_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n), .Si(si), .Co(co), .key_n(key_n), .live(live),
    .result(result), .valid(valid), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;

  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state
  logic       m_k1, m_k2, m_stable, m_valid, m_sel, mon_run;
  int         m_run, m_n;
  logic [4:0] m_res;
  logic [6:0] m_seg;
  logic [1:0] m_an;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] display(input logic s, input logic [4:0] r);
    int t, u;
    t = int'(r) / 10;
    u = int'(r) % 10;
    if (!s) return {2'b10, codes[u]};
    if (t != 0) return {2'b01, codes[t]};
    return {2'b11, 7'h7F};
  endfunction

  task automatic model_reset();
    m_k1 = 1'b1; m_k2 = 1'b1; m_stable = 1'b1; m_run = 0;
    m_res = '0; m_valid = 1'b0; m_n = 0; m_sel = 1'b0;
    m_seg = 7'h7F; m_an = 2'b11;
  endtask

  task automatic model_step();
    logic synced, cap;
    {m_an, m_seg} = display(m_sel, m_res);
    synced = m_k2;
    m_k2 = m_k1;
    m_k1 = key_n;
    cap = 1'b0;
    // A level is accepted after DB consecutive synced samples differing from the stable one
    if (synced != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = synced;
        m_run = 0;
        cap = !synced;
      end
    end else begin
      m_run = 0;
    end
    m_valid = cap;
    if (cap || live) m_res = {co, si};
    m_n++;
    m_sel = ((m_n / SCAN) % 2) == 1;
  endtask

  always @(posedge clk) begin
    mon_run = rst_n;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (mon_run && rst_n) begin
      check("result", 32'(result), 32'(m_res));
      check("valid", 32'(valid), 32'(m_valid));
      check("seg", 32'(seg), 32'(m_seg));
      check("an", 32'(an), 32'(m_an));
      if (valid) vcount++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_display(input string tag, input logic [6:0] u_seg,
                               input logic [1:0] t_an, input logic [6:0] t_seg);
    logic seen_u, seen_t;
    logic [6:0] su, st;
    logic [1:0] at;
    seen_u = 1'b0; seen_t = 1'b0; su = '0; st = '0; at = '0;
    for (int i = 0; i < 2 * SCAN + 2; i++) begin
      @(negedge clk);
      if (an == 2'b10) begin
        if (!seen_u) begin seen_u = 1'b1; su = seg; end
      end else if (!seen_t) begin
        seen_t = 1'b1; at = an; st = seg;
      end
    end
    check({tag, "_units_seen"}, 32'(seen_u), 32'd1);
    check({tag, "_units_seg"}, 32'(su), 32'(u_seg));
    check({tag, "_tens_an"}, 32'(at), 32'(t_an));
    check({tag, "_tens_seg"}, 32'(st), 32'(t_seg));
  endtask

  task automatic capture_value(input logic [4:0] v);
    {co, si} = v;
    key_n = 1'b0;
    cycles(20);
    key_n = 1'b1;
    cycles(20);
  endtask

  initial begin
    int v0, first;
    logic [4:0] r0;
    rst_n = 1'b1; si = '0; co = 1'b0; key_n = 1'b1; live = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'(2'b11));
    cycles(2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_an", 32'(an), 32'(2'b10));
    check("first_seg", 32'(seg), 32'h40);
    cycles(3);

    // Single long press captures 31 exactly once
    v0 = vcount;
    si = 4'hF; co = 1'b1;
    key_n = 1'b0; cycles(30);
    key_n = 1'b1; cycles(20);
    check("cap31_pulses", 32'(vcount - v0), 32'd1);
    check("cap31_result", 32'(result), 32'd31);
    check_display("cap31", 7'h79, 2'b01, 7'h30);

    // Bounce shorter than the debounce window is ignored
    v0 = vcount; r0 = result;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key_n = ~key_n;
      {co, si} = 5'($urandom);
      cycles(1);
    end
    key_n = 1'b1; cycles(20);
    check("bounce_pulses", 32'(vcount - v0), 32'd0);
    check("bounce_result", 32'(result), 32'(r0));

    // Live mode follows the inputs one edge later
    v0 = vcount;
    live = 1'b1; {co, si} = 5'd5; cycles(1);
    check("live5", 32'(result), 32'd5);
    {co, si} = 5'd9; cycles(1);
    check("live9", 32'(result), 32'd9);
    check_display("live9", 7'h10, 2'b11, 7'h7F);
    check("live_pulses", 32'(vcount - v0), 32'd0);
    live = 1'b0;

    capture_value(5'd10);
    check("cap10_result", 32'(result), 32'd10);
    check_display("cap10", 7'h40, 2'b01, 7'h79);

    capture_value(5'd9);
    check("cap9_result", 32'(result), 32'd9);
    check_display("cap9", 7'h10, 2'b11, 7'h7F);

    // Reset in the middle of a press restarts debouncing from scratch
    {co, si} = 5'd22;
    key_n = 1'b0; cycles(5);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_an", 32'(an), 32'(2'b11));
    cycles(2);
    rst_n = 1'b1;
    v0 = vcount; first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #2;
      if (valid && first == 0) first = i;
    end
    check("midrst_latency", 32'(first), 32'(DB + 2));
    check("midrst_pulses", 32'(vcount - v0), 32'd1);
    check("midrst_result22", 32'(result), 32'd22);
    @(negedge clk);
    key_n = 1'b1; cycles(20);

    // Randomized traffic: key runs of random length, random adder values and live mode
    for (int seg_i = 0; seg_i < 40; seg_i++) begin
      int len;
      len = int'($urandom_range(1, 14));
      key_n = ~key_n;
      live = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < len; c++) begin
        {co, si} = 5'($urandom);
        cycles(1);
      end
    end
    live = 1'b0; key_n = 1'b1; cycles(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
